// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback block.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: result source enum, default widths, NUM_REGS, and the
// writeback request record used by producers of results.
package regfile_wb_pkg;

   localparam int DATA_WIDTH         = 32;
   localparam int REG_MEM_ADDR_WIDTH = 5;
   localparam int NUM_REGS           = 1 << REG_MEM_ADDR_WIDTH;

   // Encoding matters: SRC_LSU is the reset value of the last-grant
   // register, so the ALU wins the first conflict after reset.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } wb_src_t;

   typedef struct packed {
      logic [REG_MEM_ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]         data;
   } wb_req_t;

   // The opposite source, used for alternating priority.
   function automatic wb_src_t other_src(input wb_src_t src);
      return (src == SRC_ALU) ? SRC_LSU : SRC_ALU;
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of issue, hazard, result and write-port signals around regfile_writeback.
// Latency: none (wiring only).
// Backpressure: carried by iss_ready_o / alu_ready_o / lsu_ready_o.
//
// Ports (by group):
//   issue   : iss_valid_i, iss_rd_i -> iss_ready_o
//   hazard  : rs1_i, rs2_i -> stall_o
//   results : alu_valid_i/alu_rd_i/alu_data_i -> alu_ready_o, same for lsu_*
//   write   : wr_en_o, wr_addr_o, wr_data_o ; debug busy_o
//   bypass  : byp_valid_o, byp_data_o (only when WB_BYPASS_EN is defined)
// Modports: master = environment driving decode/results, slave = regfile_writeback.
interface regfile_writeback_if #(
   parameter int DATA_WIDTH         = 32,
   parameter int REG_MEM_ADDR_WIDTH = 5
);
   localparam int NUM_REGS = 1 << REG_MEM_ADDR_WIDTH;

   logic                          iss_valid_i;
   logic [REG_MEM_ADDR_WIDTH-1:0] iss_rd_i;
   logic                          iss_ready_o;

   logic [REG_MEM_ADDR_WIDTH-1:0] rs1_i;
   logic [REG_MEM_ADDR_WIDTH-1:0] rs2_i;
   logic                          stall_o;

   logic                          alu_valid_i;
   logic                          alu_ready_o;
   logic [REG_MEM_ADDR_WIDTH-1:0] alu_rd_i;
   logic [DATA_WIDTH-1:0]         alu_data_i;

   logic                          lsu_valid_i;
   logic                          lsu_ready_o;
   logic [REG_MEM_ADDR_WIDTH-1:0] lsu_rd_i;
   logic [DATA_WIDTH-1:0]         lsu_data_i;

   logic                          wr_en_o;
   logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_o;
   logic [DATA_WIDTH-1:0]         wr_data_o;

   logic [NUM_REGS-1:0]           busy_o;

`ifdef WB_BYPASS_EN
   logic                          byp_valid_o;
   logic [DATA_WIDTH-1:0]         byp_data_o;
`endif

   modport master (
      output iss_valid_i, iss_rd_i, rs1_i, rs2_i,
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  iss_ready_o, stall_o, alu_ready_o, lsu_ready_o,
      input  wr_en_o, wr_addr_o, wr_data_o, busy_o
`ifdef WB_BYPASS_EN
      , input byp_valid_o, byp_data_o
`endif
   );

   modport slave (
      input  iss_valid_i, iss_rd_i, rs1_i, rs2_i,
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      output iss_ready_o, stall_o, alu_ready_o, lsu_ready_o,
      output wr_en_o, wr_addr_o, wr_data_o, busy_o
`ifdef WB_BYPASS_EN
      , output byp_valid_o, byp_data_o
`endif
   );

endinterface

// File: rtl/regfile_writeback_wb_arbiter.sv
// Two-way alternating-priority arbiter between the ALU and LSU/MUL result paths.
// Latency: grant and readies are combinational; last-grant state updates at the edge.
// Backpressure: only the losing source of a conflict sees ready low.
//
// Ports: clk, rst_n (sync, active low); alu_valid/lsu_valid in;
//        alu_ready/lsu_ready, grant_valid, grant_src out.
module wb_arbiter
   import regfile_wb_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    alu_valid,
   input  logic    lsu_valid,
   output logic    alu_ready,
   output logic    lsu_ready,
   output logic    grant_valid,
   output wb_src_t grant_src
);

   wb_src_t last_grant;
   logic    both;

   always_comb begin
      both        = alu_valid & lsu_valid;
      grant_valid = alu_valid | lsu_valid;
      grant_src   = SRC_ALU;
      if (both) begin
         grant_src = other_src(last_grant);
      end else if (lsu_valid) begin
         grant_src = SRC_LSU;
      end
      // The granted source is always ready, so any valid source transfers
      // unless it is the loser of a conflict.
      alu_ready = !(both && (grant_src == SRC_LSU));
      lsu_ready = !(both && (grant_src == SRC_ALU));
   end

   // Priority only flips on a real transfer; idle cycles keep the history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= SRC_LSU;
      end else if (grant_valid) begin
         last_grant <= grant_src;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write master: arbitrates ALU and LSU/MUL results, keeps the busy scoreboard.
// Latency: result transfer at cycle N -> write port at N+1; issue/stall/ready are combinational.
// Backpressure: losing result source gets ready low; issue ready low while rd is busy (WAW).
//
// Ports: clk, rst_n (synchronous, active low), bus (regfile_writeback_if.slave):
//   issue iss_valid_i/iss_rd_i/iss_ready_o, hazard rs1_i/rs2_i/stall_o,
//   results alu_*/lsu_*, write port wr_en_o/wr_addr_o/wr_data_o, debug busy_o.
// Optional: WB_BYPASS_EN adds byp_valid_o/byp_data_o and lets stall_o drop in the
//   cycle the blocking result is transferring.
module regfile_writeback
   import regfile_wb_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int REG_MEM_ADDR_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_writeback_if.slave   bus
);

   localparam int NREGS = 1 << REG_MEM_ADDR_WIDTH;

   logic [NREGS-1:0]              busy_q;
   logic [NREGS-1:0]              set_vec;
   logic [NREGS-1:0]              clr_vec;
   logic [NREGS-1:0]              stall_busy;

   logic                          arb_alu_ready;
   logic                          arb_lsu_ready;
   logic                          grant_valid;
   wb_src_t                       grant_src;

   logic                          xfer;
   logic [REG_MEM_ADDR_WIDTH-1:0] gnt_rd;
   logic [DATA_WIDTH-1:0]         gnt_data;
   logic                          gnt_rd_nz;
   logic                          iss_rd_nz;
   logic                          iss_fire;

   logic                          wr_en_q;
   logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0]         wr_data_q;

   wb_arbiter u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (bus.alu_valid_i),
      .lsu_valid   (bus.lsu_valid_i),
      .alu_ready   (arb_alu_ready),
      .lsu_ready   (arb_lsu_ready),
      .grant_valid (grant_valid),
      .grant_src   (grant_src)
   );

   // While reset is asserted every handshake output shows its reset value;
   // whatever "transfers" in that window is dropped by the sequential reset.
   always_comb begin
      bus.alu_ready_o = arb_alu_ready | !rst_n;
      bus.lsu_ready_o = arb_lsu_ready | !rst_n;
   end

   always_comb begin
      xfer      = rst_n & grant_valid;
      gnt_rd    = (grant_src == SRC_ALU) ? bus.alu_rd_i   : bus.lsu_rd_i;
      gnt_data  = (grant_src == SRC_ALU) ? bus.alu_data_i : bus.lsu_data_i;
      gnt_rd_nz = (gnt_rd != '0);
   end

   // Issue is refused only for a busy non-zero rd, which keeps at most one
   // outstanding writer per register.
   always_comb begin
      iss_rd_nz       = (bus.iss_rd_i != '0);
      bus.iss_ready_o = !rst_n | !busy_q[bus.iss_rd_i] | !iss_rd_nz;
      iss_fire        = rst_n & bus.iss_valid_i & bus.iss_ready_o;
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_fire && iss_rd_nz) begin
         set_vec[bus.iss_rd_i] = 1'b1;
      end
      if (xfer && gnt_rd_nz) begin
         clr_vec[gnt_rd] = 1'b1;
      end
   end

   // Registers whose producer is not transferring this cycle still block decode;
   // without bypass the producer's own transfer cycle also blocks.
`ifdef WB_BYPASS_EN
   always_comb begin
      stall_busy      = busy_q & ~clr_vec;
      bus.byp_valid_o = xfer && gnt_rd_nz &&
                        ((gnt_rd == bus.rs1_i) || (gnt_rd == bus.rs2_i));
      bus.byp_data_o  = gnt_data;
   end
`else
   always_comb begin
      stall_busy = busy_q;
   end
`endif

   always_comb begin
      bus.stall_o = rst_n & (stall_busy[bus.rs1_i] | stall_busy[bus.rs2_i]);
   end

   // Scoreboard; entry 0 can never be set, x0 is hardwired zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= ((busy_q & ~clr_vec) | set_vec) & ~NREGS'(1);
      end
   end

   // Registered write port; a result for x0 is consumed without a write and
   // the previous address/data are left on the port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= xfer && gnt_rd_nz;
         if (xfer && gnt_rd_nz) begin
            wr_addr_q <= gnt_rd;
            wr_data_q <= gnt_data;
         end
      end
   end

   always_comb begin
      bus.wr_en_o   = wr_en_q;
      bus.wr_addr_o = wr_addr_q;
      bus.wr_data_o = wr_data_q;
      bus.busy_o    = busy_q;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         // Issue needs !busy, so one edge can never both set and clear an entry.
         assert ((set_vec & clr_vec) == '0)
            else $error("regfile_writeback: same-edge set and clear of busy entry");
         // A result for a register nobody is waiting on is a producer bug;
         // the write still goes through.
         assert (!(xfer && gnt_rd_nz && !busy_q[gnt_rd]))
            else $error("regfile_writeback: result for non-busy rd %0d", gnt_rd);
      end
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
   import regfile_wb_pkg::*;

   logic clk;
   logic rst_n;

   regfile_writeback_if #(.DATA_WIDTH(32), .REG_MEM_ADDR_WIDTH(5)) bus ();

   regfile_writeback #(.DATA_WIDTH(32), .REG_MEM_ADDR_WIDTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        nvec = 0;
   int        nerr = 0;
   wb_req_t   exp_q[$];
   logic [31:0] model_busy;
   wb_src_t   model_last;

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: time limit reached before end of test");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      nvec++;
      assert (obs === req)
         else begin
            nerr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
         end
   endtask

   // Advance one clock and check the write port against the scoreboard:
   // a result pushed before this edge must appear now, otherwise no write.
   task automatic step();
      wb_req_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("wr_en", {63'd0, bus.wr_en_o}, 64'd1);
         chk("wr_addr", {59'd0, bus.wr_addr_o}, {59'd0, e.rd});
         chk("wr_data", {32'd0, bus.wr_data_o}, {32'd0, e.data});
      end else begin
         chk("wr_en_idle", {63'd0, bus.wr_en_o}, 64'd0);
      end
   endtask

   task automatic issue(input logic [4:0] rd);
      bus.iss_valid_i = 1'b1;
      bus.iss_rd_i    = rd;
      #1;
      chk("iss_ready", {63'd0, bus.iss_ready_o}, 64'd1);
      step();
      bus.iss_valid_i = 1'b0;
      if (rd != 5'd0) model_busy[rd] = 1'b1;
      chk("busy_after_issue", {32'd0, bus.busy_o}, {32'd0, model_busy});
   endtask

   task automatic result(input wb_src_t src, input logic [4:0] rd, input logic [31:0] data);
      wb_req_t r;
      if (src == SRC_ALU) begin
         bus.alu_valid_i = 1'b1; bus.alu_rd_i = rd; bus.alu_data_i = data;
      end else begin
         bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = rd; bus.lsu_data_i = data;
      end
      #1;
      if (src == SRC_ALU) chk("alu_ready", {63'd0, bus.alu_ready_o}, 64'd1);
      else                chk("lsu_ready", {63'd0, bus.lsu_ready_o}, 64'd1);
      r.rd = rd; r.data = data;
      if (rd != 5'd0) exp_q.push_back(r);
      step();
      bus.alu_valid_i = 1'b0;
      bus.lsu_valid_i = 1'b0;
      if (rd != 5'd0) model_busy[rd] = 1'b0;
      model_last = src;
      chk("busy_after_result", {32'd0, bus.busy_o}, {32'd0, model_busy});
   endtask

   initial begin
      wb_req_t r;
      int ai, li;
      logic both;
      wb_src_t win;

      model_busy = '0;
      model_last = SRC_LSU;
      rst_n = 1'b0;
      bus.iss_valid_i = 1'b0; bus.iss_rd_i = '0;
      bus.rs1_i = '0; bus.rs2_i = '0;
      bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
      bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0;

      // Outputs while in reset
      bus.alu_valid_i = 1'b1; bus.lsu_valid_i = 1'b1;
      #1;
      chk("rst_iss_ready", {63'd0, bus.iss_ready_o}, 64'd1);
      chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
      chk("rst_alu_ready", {63'd0, bus.alu_ready_o}, 64'd1);
      chk("rst_lsu_ready", {63'd0, bus.lsu_ready_o}, 64'd1);
      step();
      bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("idle_busy", {32'd0, bus.busy_o}, 64'd0);
      chk("idle_wr_addr", {59'd0, bus.wr_addr_o}, 64'd0);
      chk("idle_wr_data", {32'd0, bus.wr_data_o}, 64'd0);
      chk("idle_alu_ready", {63'd0, bus.alu_ready_o}, 64'd1);
      chk("idle_lsu_ready", {63'd0, bus.lsu_ready_o}, 64'd1);

      // Issue to x0 never marks busy
      issue(5'd0);

      // RAW/WAW on x5, then ALU writeback
      issue(5'd5);
      bus.rs1_i = 5'd5;
      #1;
      chk("raw_stall", {63'd0, bus.stall_o}, 64'd1);
      bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd5;
      #1;
      chk("waw_iss_ready", {63'd0, bus.iss_ready_o}, 64'd0);
      bus.iss_valid_i = 1'b0;
      result(SRC_ALU, 5'd5, 32'hA);
      #1;
      chk("stall_cleared", {63'd0, bus.stall_o}, 64'd0);
      bus.rs1_i = 5'd0;
      step();
      chk("hold_wr_addr", {59'd0, bus.wr_addr_o}, 64'd5);
      chk("hold_wr_data", {32'd0, bus.wr_data_o}, 64'hA);

      // LSU result so the ALU holds priority for the next conflict
      issue(5'd6);
      result(SRC_LSU, 5'd6, 32'h66);

      // Conflict: ALU wins, LSU held for one cycle
      issue(5'd3);
      issue(5'd4);
      bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'h30;
      bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd4; bus.lsu_data_i = 32'h40;
      #1;
      chk("conf_alu_ready", {63'd0, bus.alu_ready_o}, 64'd1);
      chk("conf_lsu_ready", {63'd0, bus.lsu_ready_o}, 64'd0);
      r.rd = 5'd3; r.data = 32'h30; exp_q.push_back(r);
      step();
      bus.alu_valid_i = 1'b0;
      #1;
      chk("conf_lsu_ready2", {63'd0, bus.lsu_ready_o}, 64'd1);
      r.rd = 5'd4; r.data = 32'h40; exp_q.push_back(r);
      step();
      bus.lsu_valid_i = 1'b0;
      model_busy[3] = 1'b0; model_busy[4] = 1'b0;
      model_last = SRC_LSU;
      chk("conf_busy", {32'd0, bus.busy_o}, {32'd0, model_busy});

      // Back-to-back conflicts on four pairs; each loser holds its request
      for (int k = 10; k < 18; k++) issue(5'(k));
      ai = 0; li = 0;
      for (int c = 0; c < 20 && (ai < 4 || li < 4); c++) begin
         bus.alu_valid_i = (ai < 4);
         bus.alu_rd_i    = 5'(10 + 2 * ai);
         bus.alu_data_i  = 32'h1000 + 32'(ai);
         bus.lsu_valid_i = (li < 4);
         bus.lsu_rd_i    = 5'(11 + 2 * li);
         bus.lsu_data_i  = 32'h2000 + 32'(li);
         #1;
         both = (ai < 4) && (li < 4);
         if (both) win = (model_last == SRC_ALU) ? SRC_LSU : SRC_ALU;
         else      win = (ai < 4) ? SRC_ALU : SRC_LSU;
         chk("b2b_alu_ready", {63'd0, bus.alu_ready_o}, {63'd0, !(both && win == SRC_LSU)});
         chk("b2b_lsu_ready", {63'd0, bus.lsu_ready_o}, {63'd0, !(both && win == SRC_ALU)});
         if (win == SRC_ALU) begin
            r.rd = bus.alu_rd_i; r.data = bus.alu_data_i;
         end else begin
            r.rd = bus.lsu_rd_i; r.data = bus.lsu_data_i;
         end
         exp_q.push_back(r);
         step();
         model_busy[r.rd] = 1'b0;
         model_last = win;
         if (win == SRC_ALU) ai++;
         else li++;
      end
      bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0;
      chk("b2b_busy", {32'd0, bus.busy_o}, {32'd0, model_busy});

      // Result for x0: consumed, no write
      result(SRC_ALU, 5'd0, 32'hFFFF);

      // Reset in the middle of a pending LSU result
      issue(5'd7);
      bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_data_i = 32'h77;
      rst_n = 1'b0;
      #1;
      chk("midrst_lsu_ready", {63'd0, bus.lsu_ready_o}, 64'd1);
      chk("midrst_stall", {63'd0, bus.stall_o}, 64'd0);
      step();
      model_busy = '0;
      model_last = SRC_LSU;
      chk("midrst_busy", {32'd0, bus.busy_o}, 64'd0);
      rst_n = 1'b1;
      bus.lsu_valid_i = 1'b0;
      step();
      chk("postrst_busy", {32'd0, bus.busy_o}, 64'd0);

`ifdef WB_BYPASS_EN
      // Bypass: result for rs1 forwarded in its transfer cycle
      issue(5'd9);
      bus.rs1_i = 5'd9;
      #1;
      chk("byp_pre_stall", {63'd0, bus.stall_o}, 64'd1);
      bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd9; bus.alu_data_i = 32'h99;
      #1;
      chk("byp_valid", {63'd0, bus.byp_valid_o}, 64'd1);
      chk("byp_data", {32'd0, bus.byp_data_o}, 64'h99);
      chk("byp_stall", {63'd0, bus.stall_o}, 64'd0);
      r.rd = 5'd9; r.data = 32'h99; exp_q.push_back(r);
      step();
      bus.alu_valid_i = 1'b0;
      bus.rs1_i = 5'd0;
      model_busy[9] = 1'b0;
      chk("byp_busy", {32'd0, bus.busy_o}, {32'd0, model_busy});
`endif

      step();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side master for register_file: arbitrates completed results from the single-cycle ALU path and the multi-cycle LSU/MUL path.
- Drives the register file write port and keeps a per-register busy scoreboard.
- Decode queries the scoreboard for RAW/WAW hazards.
- Sits between the execute/memory stages and register_file in the RISC-V core.

Parameters:
- DATA_WIDTH, 32, result/write data width
- REG_MEM_ADDR_WIDTH, 5, register index width; NUM_REGS = 1 << REG_MEM_ADDR_WIDTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- iss_valid_i  input  1  decode issuing instruction that writes rd
- iss_rd_i  input  REG_MEM_ADDR_WIDTH  destination of issuing instruction
- iss_ready_o  output  1  issue accepted (rd not busy)
- rs1_i, rs2_i  input  REG_MEM_ADDR_WIDTH  decode source registers
- stall_o  output  1  rs1 or rs2 busy (RAW hazard)
- alu_valid_i / alu_ready_o  input/output  1  ALU result handshake
- alu_rd_i  input  REG_MEM_ADDR_WIDTH; alu_data_i  input  DATA_WIDTH
- lsu_valid_i / lsu_ready_o  input/output  1  LSU/MUL result handshake
- lsu_rd_i  input  REG_MEM_ADDR_WIDTH; lsu_data_i  input  DATA_WIDTH
- wr_en_o  output  1; wr_addr_o  output  REG_MEM_ADDR_WIDTH; wr_data_o  output  DATA_WIDTH  to register_file write port
- busy_o  output  NUM_REGS  scoreboard vector (debug)

Behaviour:
- Reset (rst_n=0 at posedge): busy=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, last_grant=LSU (ALU wins the first conflict).
- Outputs during reset are combinational from reset state: iss_ready_o=1, stall_o=0, alu_ready_o=1, lsu_ready_o=1.
- Reset mid-operation discards all pending handshakes and clears the scoreboard.
- Handshake: a transfer occurs on a cycle where valid & ready. Sources hold rd/data stable while valid & !ready.
- Arbitration, combinational grant:
  - one valid source is granted;
  - both valid: the source not granted last time wins (alternating priority);
  - the loser sees ready=0.
  - last_grant updates only on an actual transfer.
- Write port is registered, latency 1: the transfer at cycle N gives wr_en_o=1, wr_addr_o=rd, wr_data_o=data at cycle N+1. With no transfer, wr_en_o=0 and addr/data hold.
- x0:
  - a result with rd=0 is accepted (ready per arbitration) but produces wr_en_o=0;
  - busy[0] is hardwired 0;
  - iss_rd_i=0 never sets busy.
- Scoreboard:
  - issue handshake (iss_valid_i & iss_ready_o) sets busy[iss_rd_i] at the next edge;
  - a result transfer clears busy[rd] at the edge that registers the write.
- iss_ready_o = !busy[iss_rd_i] | (iss_rd_i==0). WAW is stalled, so at most one outstanding writer per register.
- Same-edge set and clear of the same rd cannot occur, because issue requires !busy. Assert this in simulation.
- stall_o = busy[rs1_i] | busy[rs2_i], combinational.
- A result for a non-busy, non-zero rd is a protocol error. The write is still performed, and the simulation assertion fires.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - stall_o excludes a register whose result transfer happens this cycle (matching the granted rd);
  - adds outputs byp_valid_o (1) and byp_data_o (DATA_WIDTH), valid when the granted rd equals rs1_i or rs2_i;
  - decode proceeds one cycle earlier.
- Undefined: no bypass ports, and stall_o stays high until the busy clear edge.

Decomposition:
- Package regfile_wb_pkg holds:
  - source enum (SRC_ALU, SRC_LSU);
  - localparam NUM_REGS;
  - typedef wb_req_t {rd, data}.
- Sub-module wb_arbiter: 2-way alternating-priority arbiter producing grant/ready. Scoreboard and write register stay in the top.

Test Plan:
- Reset then idle: busy_o=0, wr_en_o=0, all readies=1; issue rd=0 keeps busy_o=0.
- Issue rd=5, then rs1_i=5 gives stall_o=1 and a second issue rd=5 gives iss_ready_o=0. ALU result rd=5 data=0xA at cycle N gives wr_en_o=1, addr=5, data=0xA at N+1, busy[5]=0 and stall_o=0.
- Issue rd=3 and rd=4. ALU (rd=3, 0x30) and LSU (rd=4, 0x40) are valid together for two cycles: ALU written first, then LSU; lsu_ready_o=0 in the first cycle.
- Back-to-back conflicts on 4 result pairs: grants alternate ALU, LSU, ALU, LSU, with no dropped write.
- ALU result rd=0 data=0xFFFF: accepted, wr_en_o stays 0.
- Assert rst_n=0 with busy[7]=1 and lsu_valid_i held high: busy cleared, wr_en_o=0 the next cycle. With WB_BYPASS_EN, a granted rd=rs1=9 data=0x99 gives byp_valid_o=1, byp_data_o=0x99, stall_o=0 in the same cycle.
